spi_xfer_ctrl: RTL and testbench
================================

# spi_xfer_ctrl

SPI master transaction controller that sequences the SPI clock divider: it holds the divider idle between transactions, drives chip select, shifts MOSI and captures MISO on the divider's leading/trailing edge strobes, and moves 1 to 8 bytes per transaction. It sits between the host-side byte interface and the divider/pad logic. The host sees a one-entry TX buffer handshake and an RX byte strobe.

## Interface
- DATA_W, 8, bits per SPI byte (MSB first)
- LEN_W, 3, width of byte-count field; transaction length = i_len+1 bytes
- SETUP_CYC, 2, cycles from CS assert to divider release
- HOLD_CYC, 2, cycles from last trailing edge to CS deassert

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  transaction request pulse; ignored while o_busy
- i_len  in  LEN_W  byte count minus one, latched at accepted start
- i_cpha  in  1  0: sample on leading, shift on trailing; 1: shift on leading, sample on trailing; latched at start
- i_tx_data  in  DATA_W  TX byte
- i_tx_valid  in  1  TX byte valid
- o_tx_ready  out  1  TX buffer empty; a byte is accepted on valid&ready
- o_rx_data  out  DATA_W  last received byte
- o_rx_valid  out  1  one-cycle strobe, o_rx_data updated
- i_lead_edge  in  1  leading-edge strobe from divider
- i_trail_edge  in  1  trailing-edge strobe from divider
- o_div_hold  out  1  holds divider counters cleared (drives its tx-valid input)
- o_cs_n  out  1  chip select, active low
- o_mosi  out  1  serial data out
- i_miso  in  1  serial data in
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle strobe at transaction end
- o_underrun  out  1  sticky; TX byte missing at a load point; cleared at next accepted start

## Operation
- States: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE: o_cs_n=1, o_div_hold=1, o_busy=0. i_start accepted -> SETUP; i_len, i_cpha latched; o_underrun cleared.
- SETUP: o_cs_n=0, o_busy=1, count SETUP_CYC cycles, then -> XFER. CPHA=0: byte 0 loaded into shift register on SETUP entry; o_mosi = bit 7.
- XFER: o_div_hold=0. Edge strobes honoured only in XFER.
  - Sample edge (lead if CPHA=0, trail if CPHA=1): shift i_miso into RX register, increment bit count (3-bit, wraps 7->0).
  - Shift edge (trail if CPHA=0, lead if CPHA=1): o_mosi advances to next bit.
  - Load point: CPHA=0, trailing edge completing a byte; CPHA=1, first leading edge of each byte. The shift register loads from the TX buffer; buffer empty -> load 0x00 and set o_underrun. Buffer empty with i_tx_valid high in the same cycle -> that byte loads directly, no underrun.
  - 8th sample of a byte: o_rx_data <= assembled byte, o_rx_valid pulses next cycle.
  - Trailing edge completing byte i_len -> HOLD, byte counter compared at full LEN_W width; no further load.
- HOLD: o_div_hold=1, o_cs_n=0 for HOLD_CYC cycles, then o_cs_n=1, o_done pulses one cycle, -> IDLE.
- TX buffer: one entry, writable in any state (pre-fill byte 0 in IDLE).
- Reset (any time, incl. mid-transaction): o_cs_n=1, o_div_hold=1, o_mosi=0, o_tx_ready=1 (buffer emptied), o_rx_data=0, o_rx_valid=0, o_busy=0, o_done=0, o_underrun=0, state IDLE.

## Timing
- Start in cycle 0 -> o_cs_n=0, o_busy=1 in cycle 1; o_div_hold=0 from cycle 1+SETUP_CYC.
- o_rx_valid: 1 cycle after the sampling strobe of bit 0.
- o_done: HOLD_CYC+1 cycles after final trailing strobe, same cycle o_cs_n rises; o_busy low the following cycle.
- i_start coincident with o_done ignored.
- TX acceptance: o_tx_ready falls the cycle after valid&ready, rises the cycle after a load.

## Structure
- Package spi_pkg: state enum, DATA_W, LEN_W, SETUP_CYC/HOLD_CYC defaults.
- Sub-module spi_shift_unit: TX/RX shift registers, 3-bit bit counter, byte-complete flag; controller FSM and TX buffer in top.

## Test plan
- CPHA=0, len=0, TX 0xA5 pre-filled, MISO replays 0x3C -> MOSI 1,0,1,0,0,1,0,1 at sample edges; o_rx_data=0x3C, one o_done, o_underrun=0.
- CPHA=1, len=2, TX 0x01,0x80,0xFF supplied just in time -> 24 bits correct, three o_rx_valid pulses, CS low for whole transfer.
- len=1, second byte never supplied -> second byte transmits 0x00, o_underrun=1 until next start.
- i_start pulsed during XFER and on o_done cycle -> ignored, no second transaction.
- i_rst raised mid-byte 5 -> next cycle o_cs_n=1, o_div_hold=1, o_tx_ready=1, all strobes low; fresh start completes normally.
- len=7 (8 bytes) -> byte counter reaches 7 without wrap error, exactly 8 o_rx_valid pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI master transaction controller.
// DATA_W must be at least 3 so the RX shift register slices stay legal.
package spi_pkg;

    localparam int DATA_W    = 8;
    localparam int LEN_W     = 3;
    localparam int SETUP_CYC = 2;
    localparam int HOLD_CYC  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/spi_xfer_ctrl_shift.sv
// Serial datapath: TX/RX shift registers, per-byte bit counter and byte-end detection.
// The controller decides when to load and shift; this unit only tracks bit position.
module spi_shift_unit
    import spi_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_cpha,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_shift,
    input  logic              i_sample,
    input  logic              i_trail,
    input  logic              i_miso,
    output logic              o_mosi,
    output logic              o_byte_start,
    output logic              o_byte_end,
    output logic              o_rx_strobe,
    output logic [DATA_W-1:0] o_rx_byte
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-2:0] rx_sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic              byte_full;
    logic              last_bit;

    assign last_bit = (bit_cnt == LAST_BIT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_sr <= '0;
        end else if (i_load) begin
            tx_sr <= i_load_data;
        end else if (i_shift) begin
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end
    end

    // byte_full bridges the 8th leading-edge sample to the trailing edge that
    // closes the byte when CPHA=0; with CPHA=1 the closing edge is the sample itself.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_sr     <= '0;
            bit_cnt   <= '0;
            byte_full <= 1'b0;
        end else if (i_clear) begin
            bit_cnt   <= '0;
            byte_full <= 1'b0;
        end else begin
            if (i_sample) begin
                rx_sr   <= {rx_sr[DATA_W-3:0], i_miso};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (i_sample && last_bit) begin
                byte_full <= 1'b1;
            end else if (i_trail) begin
                byte_full <= 1'b0;
            end
        end
    end

    assign o_mosi       = tx_sr[DATA_W-1];
    assign o_byte_start = (bit_cnt == '0);
    assign o_byte_end   = i_trail & (i_cpha ? last_bit : byte_full);
    assign o_rx_strobe  = i_sample & last_bit;
    assign o_rx_byte    = {rx_sr, i_miso};

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transaction controller: sequences CS, the divider hold and byte loads
// around a one-entry TX buffer, and reports received bytes and completion.
module spi_xfer_ctrl
    import spi_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_cpha,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_lead_edge,
    input  logic              i_trail_edge,
    output logic              o_div_hold,
    output logic              o_cs_n,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_underrun
);

    localparam int CYC_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(SETUP_CYC - 1);
    localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'(HOLD_CYC);

    state_t            state, state_nxt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  byte_cnt;
    logic              cpha_q;
    logic [DATA_W-1:0] tx_buf;
    logic              tx_full;

    logic              start_acc;
    logic              in_xfer;
    logic              lead;
    logic              trail;
    logic              sample;
    logic              shift_edge;
    logic              load;
    logic              shift;
    logic              load_empty;
    logic [DATA_W-1:0] load_data;
    logic              last_byte;
    logic              byte_start;
    logic              byte_end;
    logic              rx_strobe;
    logic [DATA_W-1:0] rx_byte;

    assign start_acc  = (state == ST_IDLE) & i_start;
    assign in_xfer    = (state == ST_XFER);
    assign lead       = i_lead_edge & in_xfer;
    assign trail      = i_trail_edge & in_xfer;
    assign sample     = cpha_q ? trail : lead;
    assign shift_edge = cpha_q ? lead : trail;
    assign last_byte  = (byte_cnt == len_q);

    // CPHA=0 needs byte 0 on the wire before the first edge, so it loads as the
    // start is accepted; later bytes load where the shift would otherwise happen.
    assign load = (start_acc & ~i_cpha)
                | (cpha_q & lead & byte_start)
                | (~cpha_q & byte_end & ~last_byte);
    assign shift = shift_edge & ~load;

    assign load_empty = ~tx_full & ~i_tx_valid;
    assign load_data  = tx_full ? tx_buf : (i_tx_valid ? i_tx_data : '0);
    assign o_tx_ready = ~tx_full;

    spi_shift_unit u_shift (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (start_acc),
        .i_cpha       (cpha_q),
        .i_load       (load),
        .i_load_data  (load_data),
        .i_shift      (shift),
        .i_sample     (sample),
        .i_trail      (trail),
        .i_miso       (i_miso),
        .o_mosi       (o_mosi),
        .o_byte_start (byte_start),
        .o_byte_end   (byte_end),
        .o_rx_strobe  (rx_strobe),
        .o_rx_byte    (rx_byte)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cyc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cyc_cnt <= '0;
            end else if (state == ST_SETUP || state == ST_HOLD) begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
        end
    end

    // HOLD runs one extra cycle past HOLD_CYC so CS can rise with the done strobe
    // while busy is still asserted.
    always_comb begin
        state_nxt  = state;
        o_cs_n     = 1'b1;
        o_div_hold = 1'b1;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                o_cs_n = 1'b0;
                o_busy = 1'b1;
                if (cyc_cnt == SETUP_LAST) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                o_cs_n     = 1'b0;
                o_busy     = 1'b1;
                o_div_hold = 1'b0;
                if (byte_end && last_byte) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                o_busy = 1'b1;
                if (cyc_cnt == HOLD_LAST) begin
                    o_done    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    o_cs_n = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A byte offered while the buffer is empty at a load point goes straight to
    // the shift register and never occupies the buffer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_full <= 1'b0;
            tx_buf  <= '0;
        end else if (load && tx_full) begin
            tx_full <= 1'b0;
        end else if (i_tx_valid && !tx_full && !load) begin
            tx_full <= 1'b1;
            tx_buf  <= i_tx_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            len_q      <= '0;
            cpha_q     <= 1'b0;
            byte_cnt   <= '0;
            o_underrun <= 1'b0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            if (start_acc) begin
                len_q    <= i_len;
                cpha_q   <= i_cpha;
                byte_cnt <= '0;
            end else if (byte_end && !last_byte) begin
                byte_cnt <= byte_cnt + LEN_W'(1);
            end
            if (load && load_empty) begin
                o_underrun <= 1'b1;
            end else if (start_acc) begin
                o_underrun <= 1'b0;
            end
            o_rx_valid <= rx_strobe;
            if (rx_strobe) o_rx_data <= rx_byte;
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: a divider/slave model drives edges and MISO,
// expected MOSI bits, RX bytes and completion status are queued and checked as they appear.
module tb_spi_xfer_ctrl;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [2:0] i_len;
    logic       i_cpha;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       i_lead_edge;
    logic       i_trail_edge;
    logic       o_div_hold;
    logic       o_cs_n;
    logic       o_mosi;
    logic       i_miso;
    logic       o_busy;
    logic       o_done;
    logic       o_underrun;

    spi_xfer_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_cpha       (i_cpha),
        .i_tx_data    (i_tx_data),
        .i_tx_valid   (i_tx_valid),
        .o_tx_ready   (o_tx_ready),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .i_lead_edge  (i_lead_edge),
        .i_trail_edge (i_trail_edge),
        .o_div_hold   (o_div_hold),
        .o_cs_n       (o_cs_n),
        .o_mosi       (o_mosi),
        .i_miso       (i_miso),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_underrun   (o_underrun)
    );

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int cs_glitch = 0;
    bit cpha_cur = 0;

    logic       exp_mosi[$];
    logic       miso_q[$];
    logic [7:0] exp_rx[$];
    logic       exp_done[$];

    logic [63:0] feed_bytes;
    int          feed_first;
    int          feed_n;

    initial begin
        i_clk = 0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got unexpected or missing event expected none", name);
    endtask

    task automatic writeTx(input logic [7:0] b);
        int n = 0;
        @(negedge i_clk);
        i_tx_valid = 1;
        i_tx_data  = b;
        while (!o_tx_ready && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_tx_ready) reportFail("tx_accept_timeout");
        @(negedge i_clk);
        i_tx_valid = 0;
    endtask

    // Divider and slave model: edges every 4 cycles while released; MISO and the
    // MOSI comparison are tied to the sampling edge of the selected phase.
    initial begin
        int  dcnt;
        bit  samp;
        dcnt = 0;
        i_lead_edge = 0;
        i_trail_edge = 0;
        i_miso = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst || o_div_hold) begin
                dcnt = 0;
                i_lead_edge = 0;
                i_trail_edge = 0;
            end else begin
                i_lead_edge  = (dcnt == 1);
                i_trail_edge = (dcnt == 3);
                dcnt = (dcnt + 1) % 4;
                samp = cpha_cur ? i_trail_edge : i_lead_edge;
                if (samp) begin
                    if (exp_mosi.size() == 0) reportFail("mosi_extra_bit");
                    else checkOutput("mosi_bit", o_mosi, exp_mosi.pop_front());
                    i_miso = (miso_q.size() != 0) ? miso_q.pop_front() : 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                if (o_rx_valid) begin
                    rx_cnt++;
                    if (exp_rx.size() == 0) reportFail("rx_extra_byte");
                    else checkOutput("rx_data", o_rx_data, exp_rx.pop_front());
                end
                if (o_done) begin
                    if (exp_done.size() == 0) reportFail("done_extra");
                    else checkOutput("underrun_at_done", o_underrun, exp_done.pop_front());
                    checkOutput("cs_at_done", o_cs_n, 1);
                end
                if (o_busy && !o_done && o_cs_n) cs_glitch++;
            end
        end
    end

    task automatic applyStimulus(input bit cpha, input logic [2:0] len, input int n_supply,
                                 input bit prefill, input logic [63:0] tx_bytes,
                                 input logic [63:0] rx_bytes);
        logic [7:0] b;
        cpha_cur = cpha;
        for (int k = 0; k <= int'(len); k++) begin
            b = (k < n_supply) ? tx_bytes[63-8*k -: 8] : 8'h00;
            for (int j = 7; j >= 0; j--) exp_mosi.push_back(b[j]);
            b = rx_bytes[63-8*k -: 8];
            for (int j = 7; j >= 0; j--) miso_q.push_back(b[j]);
            exp_rx.push_back(b);
        end
        exp_done.push_back(n_supply <= int'(len));
        if (prefill) begin
            writeTx(tx_bytes[63:56]);
            checkOutput("tx_ready_after_write", o_tx_ready, 0);
        end
        feed_bytes = tx_bytes;
        feed_first = prefill ? 1 : 0;
        feed_n     = n_supply;
        @(negedge i_clk);
        i_len   = len;
        i_cpha  = cpha;
        i_start = 1;
        @(negedge i_clk);
        i_start = 0;
        fork
            begin
                for (int k = feed_first; k < feed_n; k++) writeTx(feed_bytes[63-8*k -: 8]);
            end
        join_none
    endtask

    task automatic finishTransaction(input bit start_on_done, input int rx_before, input int n_rx);
        int n = 0;
        while (!o_done && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_done) reportFail("done_timeout");
        else if (start_on_done) i_start = 1;
        @(negedge i_clk);
        i_start = 0;
        checkOutput("busy_after_done", o_busy, 0);
        checkOutput("cs_after_done", o_cs_n, 1);
        repeat (4) @(negedge i_clk);
        checkOutput("no_restart", o_busy, 0);
        checkOutput("rx_count", rx_cnt - rx_before, n_rx);
        checkOutput("mosi_bits_left", exp_mosi.size(), 0);
        checkOutput("cs_low_span", cs_glitch, 0);
    endtask

    initial begin
        int rx_before;
        int n;
        i_rst = 0;
        i_start = 0;
        i_len = 0;
        i_cpha = 0;
        i_tx_data = 0;
        i_tx_valid = 0;
        #1 i_rst = 1;
        repeat (2) @(negedge i_clk);
        checkOutput("rst_cs_n", o_cs_n, 1);
        checkOutput("rst_div_hold", o_div_hold, 1);
        checkOutput("rst_mosi", o_mosi, 0);
        checkOutput("rst_tx_ready", o_tx_ready, 1);
        checkOutput("rst_rx_data", o_rx_data, 0);
        checkOutput("rst_rx_valid", o_rx_valid, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_underrun", o_underrun, 0);
        i_rst = 0;
        repeat (2) @(negedge i_clk);

        // CPHA=0, single byte, prefilled buffer
        $display("[TB] cpha0 single byte");
        cs_glitch = 0;
        rx_before = rx_cnt;
        applyStimulus(0, 3'd0, 1, 1, 64'hA5000000_00000000, 64'h3C000000_00000000);
        checkOutput("cyc1_cs_n", o_cs_n, 0);
        checkOutput("cyc1_busy", o_busy, 1);
        checkOutput("cyc1_div_hold", o_div_hold, 1);
        checkOutput("cyc1_tx_ready", o_tx_ready, 1);
        @(negedge i_clk);
        checkOutput("cyc2_div_hold", o_div_hold, 1);
        @(negedge i_clk);
        checkOutput("cyc3_div_hold", o_div_hold, 0);
        finishTransaction(0, rx_before, 1);
        checkOutput("t1_rx_data", o_rx_data, 8'h3C);
        checkOutput("t1_underrun", o_underrun, 0);

        // CPHA=1, three bytes fed while running
        $display("[TB] cpha1 three bytes");
        cs_glitch = 0;
        rx_before = rx_cnt;
        applyStimulus(1, 3'd2, 3, 0, 64'h0180FF00_00000000, 64'hDEADBE00_00000000);
        finishTransaction(0, rx_before, 3);
        checkOutput("t2_underrun", o_underrun, 0);

        // Second byte never supplied
        $display("[TB] underrun");
        cs_glitch = 0;
        rx_before = rx_cnt;
        applyStimulus(0, 3'd1, 1, 1, 64'h5A000000_00000000, 64'hC3810000_00000000);
        finishTransaction(0, rx_before, 2);
        checkOutput("t3_underrun_sticky", o_underrun, 1);

        // Start pulses during XFER and on the done cycle are ignored
        $display("[TB] ignored starts");
        cs_glitch = 0;
        rx_before = rx_cnt;
        applyStimulus(0, 3'd0, 1, 1, 64'h96000000_00000000, 64'h69000000_00000000);
        checkOutput("t4_underrun_cleared", o_underrun, 0);
        n = 0;
        while (o_div_hold && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (o_div_hold) reportFail("xfer_timeout");
        repeat (6) @(negedge i_clk);
        i_start = 1;
        @(negedge i_clk);
        i_start = 0;
        finishTransaction(1, rx_before, 1);

        // Reset in the middle of the fifth byte
        $display("[TB] mid-transfer reset");
        cs_glitch = 0;
        rx_before = rx_cnt;
        applyStimulus(0, 3'd7, 1, 1, 64'hC3000000_00000000, 64'h11223344_55667788);
        n = 0;
        while ((rx_cnt - rx_before) < 4 && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if ((rx_cnt - rx_before) < 4) reportFail("rx4_timeout");
        repeat (4) @(negedge i_clk);
        writeTx(8'h77);
        checkOutput("t5_tx_full", o_tx_ready, 0);
        checkOutput("t5_underrun_set", o_underrun, 1);
        repeat (3) @(negedge i_clk);
        #2 i_rst = 1;
        exp_mosi.delete();
        miso_q.delete();
        exp_rx.delete();
        exp_done.delete();
        @(negedge i_clk);
        checkOutput("mid_rst_cs_n", o_cs_n, 1);
        checkOutput("mid_rst_div_hold", o_div_hold, 1);
        checkOutput("mid_rst_tx_ready", o_tx_ready, 1);
        checkOutput("mid_rst_rx_valid", o_rx_valid, 0);
        checkOutput("mid_rst_done", o_done, 0);
        checkOutput("mid_rst_busy", o_busy, 0);
        checkOutput("mid_rst_underrun", o_underrun, 0);
        checkOutput("mid_rst_rx_data", o_rx_data, 0);
        @(negedge i_clk);
        i_rst = 0;
        repeat (2) @(negedge i_clk);

        // Fresh eight-byte transfer after reset
        $display("[TB] cpha1 eight bytes");
        cs_glitch = 0;
        rx_before = rx_cnt;
        applyStimulus(1, 3'd7, 8, 0, 64'h0180FF3C_A55A0FF0, 64'h12345678_9ABCDEF0);
        finishTransaction(0, rx_before, 8);
        checkOutput("t6_underrun", o_underrun, 0);
        checkOutput("t6_rx_data", o_rx_data, 8'hF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
